// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port between the multicycle sequencer and memory.
// Handshake: mem_req is raised by the sequencer and held, with iord/memwrite stable, until a
// cycle with mem_ready=1 completes the access; mem_ready seen while mem_req=0 means nothing.
interface multicycle_sequencer_if;
  logic mem_req;
  logic iord;
  logic memwrite;
  logic mem_ready;

  modport master (
    output mem_req,
    output iord,
    output memwrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  iord,
    input  memwrite,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle LEGv8 core: FETCH/DECODE/EXEC/MEM/WB over one shared memory
// port, with a memory stall watchdog, a sticky fault flag and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int          OPCODESIZE   = 11,
  parameter int          ALUOPSIZE    = 4,
  parameter int          MEM_TIMEOUT  = 255,
  parameter logic [31:0] INSTRET_INIT = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [OPCODESIZE-1:0] opcode,
  input  logic                  alu_zero,
  multicycle_sequencer_if.master mem,
  output logic                  irwrite,
  output logic                  pcwrite,
  output logic                  pcsrc,
  output logic                  alusrc,
  output logic [ALUOPSIZE-1:0]  aluop,
  output logic                  regwrite,
  output logic [1:0]            regsrc,
  output logic                  setflags,
  output logic [31:0]           instret,
  output logic                  fault,
  output logic [2:0]            state_dbg
);

  localparam logic [ALUOPSIZE-1:0] ALU_AND   = ALUOPSIZE'(0);
  localparam logic [ALUOPSIZE-1:0] ALU_ORR   = ALUOPSIZE'(1);
  localparam logic [ALUOPSIZE-1:0] ALU_ADD   = ALUOPSIZE'(2);
  localparam logic [ALUOPSIZE-1:0] ALU_SUB   = ALUOPSIZE'(6);
  localparam logic [ALUOPSIZE-1:0] ALU_PASSB = ALUOPSIZE'(7);

  localparam logic [1:0] REGSRC_ALU = 2'd0;
  localparam logic [1:0] REGSRC_MEM = 2'd1;

  localparam logic [15:0] STALL_LIMIT = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_RTYPE, C_ADDI, C_LDUR, C_STUR, C_CBZ, C_B
  } cls_t;

  state_t                 state, state_next;
  cls_t                   cls;
  logic                   is_adds;
  logic [ALUOPSIZE-1:0]   r_aluop;
  logic [15:0]            stall_cnt, stall_next;
  logic                   retire;
  logic [10:0]            op;

  assign op        = opcode[10:0];
  assign state_dbg = state;

  always_comb begin
    cls     = C_ILL;
    is_adds = 1'b0;
    r_aluop = ALU_ADD;
    if (op == 11'h458) begin
      cls = C_RTYPE;
    end else if (op == 11'h658) begin
      cls     = C_RTYPE;
      r_aluop = ALU_SUB;
    end else if (op == 11'h450) begin
      cls     = C_RTYPE;
      r_aluop = ALU_AND;
    end else if (op == 11'h550) begin
      cls     = C_RTYPE;
      r_aluop = ALU_ORR;
    end else if (op == 11'h558) begin
      cls     = C_RTYPE;
      is_adds = 1'b1;
    end else if (op[10:1] == 10'h244) begin
      cls = C_ADDI;
    end else if (op == 11'h7C2) begin
      cls = C_LDUR;
    end else if (op == 11'h7C0) begin
      cls = C_STUR;
    end else if (op[10:3] == 8'b1011_0100) begin
      cls = C_CBZ;
    end else if (op[10:5] == 6'b000101) begin
      cls = C_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      stall_cnt <= 16'd0;
      instret   <= INSTRET_INIT;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_next;
      if (retire) instret <= instret + 32'd1;
    end
  end

  // A nonzero stall count in FETCH marks an outstanding fetch, so dropping run cannot
  // withdraw a request that memory has not yet completed.
  always_comb begin
    state_next   = state;
    stall_next   = stall_cnt;
    retire       = 1'b0;
    mem.mem_req  = 1'b0;
    mem.iord     = 1'b0;
    mem.memwrite = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    pcsrc        = 1'b0;
    alusrc       = 1'b0;
    aluop        = '0;
    regwrite     = 1'b0;
    regsrc       = REGSRC_ALU;
    setflags     = 1'b0;
    fault        = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          if (run || stall_cnt != 16'd0) begin
            mem.mem_req = 1'b1;
            if (mem.mem_ready) begin
              irwrite    = 1'b1;
              pcwrite    = 1'b1;
              stall_next = 16'd0;
              state_next = DECODE;
            end else if (stall_cnt == STALL_LIMIT) begin
              state_next = FAULT;
            end else begin
              stall_next = stall_cnt + 16'd1;
            end
          end
        end
        DECODE: state_next = (cls == C_ILL) ? FAULT : EXEC;
        EXEC: begin
          unique case (cls)
            C_RTYPE, C_ADDI: begin
              aluop      = r_aluop;
              alusrc     = (cls == C_ADDI);
              state_next = WB;
            end
            C_LDUR, C_STUR: begin
              aluop      = ALU_ADD;
              alusrc     = 1'b1;
              stall_next = 16'd0;
              state_next = MEM;
            end
            C_CBZ: begin
              aluop      = ALU_PASSB;
              pcwrite    = alu_zero;
              pcsrc      = 1'b1;
              retire     = 1'b1;
              stall_next = 16'd0;
              state_next = FETCH;
            end
            C_B: begin
              pcwrite    = 1'b1;
              pcsrc      = 1'b1;
              retire     = 1'b1;
              stall_next = 16'd0;
              state_next = FETCH;
            end
            default: state_next = FAULT;
          endcase
        end
        MEM: begin
          mem.mem_req  = 1'b1;
          mem.iord     = 1'b1;
          mem.memwrite = (cls == C_STUR);
          if (mem.mem_ready) begin
            stall_next = 16'd0;
            if (cls == C_STUR) begin
              retire     = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = WB;
            end
          end else if (stall_cnt == STALL_LIMIT) begin
            state_next = FAULT;
          end else begin
            stall_next = stall_cnt + 16'd1;
          end
        end
        WB: begin
          regwrite   = 1'b1;
          regsrc     = (cls == C_LDUR) ? REGSRC_MEM : REGSRC_ALU;
          setflags   = is_adds;
          retire     = 1'b1;
          stall_next = 16'd0;
          state_next = FETCH;
        end
        FAULT: fault = 1'b1;
        default: state_next = FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle vector table plus hand-written
// sequences for illegal opcode, fetch timeout and reset in the middle of an access.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_X = 3'd5;
  localparam logic [3:0] A_AND = 4'd0, A_ORR = 4'd1, A_ADD = 4'd2, A_SUB = 4'd6, A_PASSB = 4'd7;
  localparam logic [1:0] R_ALU = 2'd0, R_MEM = 2'd1;
  localparam logic [10:0] OP_STUR = 11'h7C0, OP_B = 11'h0A0;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcsrc;
    logic       alusrc;
    logic [3:0] aluop;
    logic       regwrite;
    logic [1:0] regsrc;
    logic       setflags;
    logic       fault;
  } outs_t;

  localparam int W = $bits(outs_t);

  typedef struct {
    logic        run;
    logic [10:0] opcode;
    logic        alu_zero;
    logic        mem_ready;
    outs_t       exp;
    logic [31:0] ret;
    string       tag;
  } vec_t;

  // clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [10:0] opcode = 11'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  multicycle_sequencer_if bus ();
  multicycle_sequencer_if bus_w ();
  assign bus.mem_ready   = mem_ready;
  assign bus_w.mem_ready = mem_ready;

  logic        irwrite, pcwrite, pcsrc, alusrc, regwrite, setflags, fault;
  logic [3:0]  aluop;
  logic [1:0]  regsrc;
  logic [31:0] instret;
  logic [2:0]  state_dbg;

  logic        w_irwrite, w_pcwrite, w_pcsrc, w_alusrc, w_regwrite, w_setflags, w_fault;
  logic [3:0]  w_aluop;
  logic [1:0]  w_regsrc;
  logic [31:0] w_instret;
  logic [2:0]  w_state_dbg;

  multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_zero(alu_zero), .mem(bus),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop),
    .regwrite(regwrite), .regsrc(regsrc), .setflags(setflags), .instret(instret),
    .fault(fault), .state_dbg(state_dbg)
  );

  multicycle_sequencer #(.MEM_TIMEOUT(4), .INSTRET_INIT(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_zero(alu_zero), .mem(bus_w),
    .irwrite(w_irwrite), .pcwrite(w_pcwrite), .pcsrc(w_pcsrc), .alusrc(w_alusrc),
    .aluop(w_aluop), .regwrite(w_regwrite), .regsrc(w_regsrc), .setflags(w_setflags),
    .instret(w_instret), .fault(w_fault), .state_dbg(w_state_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic outs_t o_base(logic [2:0] s);
    outs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic outs_t o_fetch(logic done);
    outs_t o = o_base(S_F);
    o.mem_req = 1'b1;
    o.irwrite = done;
    o.pcwrite = done;
    return o;
  endfunction

  function automatic outs_t o_exec(logic [3:0] al, logic src);
    outs_t o = o_base(S_E);
    o.aluop  = al;
    o.alusrc = src;
    return o;
  endfunction

  function automatic outs_t o_branch(logic [3:0] al, logic pcw);
    outs_t o = o_base(S_E);
    o.aluop   = al;
    o.pcwrite = pcw;
    o.pcsrc   = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_mem(logic wr);
    outs_t o = o_base(S_M);
    o.mem_req  = 1'b1;
    o.iord     = 1'b1;
    o.memwrite = wr;
    return o;
  endfunction

  function automatic outs_t o_wb(logic [1:0] rs, logic sf);
    outs_t o = o_base(S_W);
    o.regwrite = 1'b1;
    o.regsrc   = rs;
    o.setflags = sf;
    return o;
  endfunction

  function automatic outs_t o_fault();
    outs_t o = o_base(S_X);
    o.fault = 1'b1;
    return o;
  endfunction

  // driver: one clock cycle of inputs, then compare outputs mid-cycle
  task automatic cyc(input logic r, input logic rn, input logic [10:0] opc, input logic z,
                     input logic rdy, input outs_t e, input logic [31:0] ret, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] want;
    @(posedge clk);
    #1;
    rst       = r;
    run       = rn;
    opcode    = opc;
    alu_zero  = z;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    got = {state_dbg, bus.mem_req, bus.iord, bus.memwrite, irwrite, pcwrite, pcsrc, alusrc,
           aluop, regwrite, regsrc, setflags, fault};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s outputs: got %b want %b (t=%0t)", tag, got, want, $time);
    end
    n_cmp++;
    if (instret !== ret) begin
      n_bad++;
      $display("FAIL %s instret: got %h want %h (t=%0t)", tag, instret, ret, $time);
    end
  endtask

  // vector table
  vec_t        tbl[$];
  logic [31:0] ret_n;

  function automatic void add(logic rn, logic [10:0] opc, logic z, logic rdy, outs_t e,
                              string tag);
    vec_t v;
    v.run       = rn;
    v.opcode    = opc;
    v.alu_zero  = z;
    v.mem_ready = rdy;
    v.exp       = e;
    v.ret       = ret_n;
    v.tag       = tag;
    tbl.push_back(v);
  endfunction

  function automatic void add_alu(logic [10:0] opc, logic [3:0] al, logic src, logic sf,
                                  string tag);
    add(1'b1, opc, 1'b0, 1'b1, o_fetch(1'b1), tag);
    add(1'b1, opc, 1'b0, 1'b1, o_base(S_D), tag);
    add(1'b1, opc, 1'b0, 1'b1, o_exec(al, src), tag);
    add(1'b1, opc, 1'b0, 1'b1, o_wb(R_ALU, sf), tag);
    ret_n++;
  endfunction

  function automatic void add_branch(logic [10:0] opc, logic z, logic [3:0] al, logic pcw,
                                     string tag);
    add(1'b1, opc, z, 1'b1, o_fetch(1'b1), tag);
    add(1'b1, opc, z, 1'b1, o_base(S_D), tag);
    add(1'b1, opc, z, 1'b1, o_branch(al, pcw), tag);
    ret_n++;
  endfunction

  initial begin
    ret_n = 32'd0;
    add(1'b0, 11'h458, 1'b0, 1'b1, o_base(S_F), "idle_run0");
    add_alu(11'h458, A_ADD, 1'b0, 1'b0, "add");
    add_alu(11'h558, A_ADD, 1'b0, 1'b1, "adds");
    add_alu(11'h658, A_SUB, 1'b0, 1'b0, "sub");
    add_alu(11'h450, A_AND, 1'b0, 1'b0, "and");
    add_alu(11'h550, A_ORR, 1'b0, 1'b0, "orr");
    add_alu(11'h489, A_ADD, 1'b1, 1'b0, "addi");
    // LDUR with three stall cycles in MEM; ready lands on the last permitted stall
    add(1'b1, 11'h7C2, 1'b0, 1'b1, o_fetch(1'b1), "ldur");
    add(1'b1, 11'h7C2, 1'b0, 1'b1, o_base(S_D), "ldur");
    add(1'b1, 11'h7C2, 1'b0, 1'b1, o_exec(A_ADD, 1'b1), "ldur");
    for (int i = 0; i < 3; i++) add(1'b1, 11'h7C2, 1'b0, 1'b0, o_mem(1'b0), "ldur_stall");
    add(1'b1, 11'h7C2, 1'b0, 1'b1, o_mem(1'b0), "ldur_done");
    add(1'b1, 11'h7C2, 1'b0, 1'b1, o_wb(R_MEM, 1'b0), "ldur_wb");
    ret_n++;
    add(1'b1, OP_STUR, 1'b0, 1'b1, o_fetch(1'b1), "stur");
    add(1'b1, OP_STUR, 1'b0, 1'b1, o_base(S_D), "stur");
    add(1'b1, OP_STUR, 1'b0, 1'b1, o_exec(A_ADD, 1'b1), "stur");
    add(1'b1, OP_STUR, 1'b0, 1'b1, o_mem(1'b1), "stur_mem");
    ret_n++;
    add_branch(11'h5A0, 1'b1, A_PASSB, 1'b1, "cbz_taken");
    add_branch(11'h5A7, 1'b0, A_PASSB, 1'b0, "cbz_not");
    add_branch(OP_B, 1'b0, 4'd0, 1'b1, "b");
    // fetch stalls three cycles, ready on the last permitted stall
    for (int i = 0; i < 3; i++) add(1'b1, 11'h0BF, 1'b0, 1'b0, o_fetch(1'b0), "b_fstall");
    add(1'b1, 11'h0BF, 1'b0, 1'b1, o_fetch(1'b1), "b_fdone");
    add(1'b1, 11'h0BF, 1'b0, 1'b1, o_base(S_D), "b_stalled");
    add(1'b1, 11'h0BF, 1'b0, 1'b1, o_branch(4'd0, 1'b1), "b_stalled");
    ret_n++;
    // run drops in EXEC of STUR: the write still happens, then the FSM idles
    add(1'b1, OP_STUR, 1'b0, 1'b1, o_fetch(1'b1), "stur_drop");
    add(1'b1, OP_STUR, 1'b0, 1'b1, o_base(S_D), "stur_drop");
    add(1'b0, OP_STUR, 1'b0, 1'b1, o_exec(A_ADD, 1'b1), "stur_drop");
    add(1'b0, OP_STUR, 1'b0, 1'b1, o_mem(1'b1), "stur_drop_mem");
    ret_n++;
    add(1'b0, OP_STUR, 1'b0, 1'b1, o_base(S_F), "drained_idle");
    add(1'b0, OP_STUR, 1'b0, 1'b1, o_base(S_F), "drained_idle");

    // reset: strobes held low even with run and mem_ready high
    cyc(1'b1, 1'b1, 11'h458, 1'b0, 1'b1, o_base(S_F), 32'd0, "reset");
    cyc(1'b1, 1'b1, 11'h458, 1'b0, 1'b1, o_base(S_F), 32'd0, "reset");

    foreach (tbl[i]) begin
      cyc(1'b0, tbl[i].run, tbl[i].opcode, tbl[i].alu_zero, tbl[i].mem_ready, tbl[i].exp,
          tbl[i].ret, tbl[i].tag);
      n_cmp++;
      if (w_instret !== tbl[i].ret + 32'hFFFF_FFFE) begin
        n_bad++;
        $display("FAIL %s wrap_instret: got %h want %h", tbl[i].tag, w_instret,
                 tbl[i].ret + 32'hFFFF_FFFE);
      end
    end
    n_cmp++;
    if (w_instret !== 32'd11) begin
      n_bad++;
      $display("FAIL wrap_final instret: got %h want %h", w_instret, 32'd11);
    end

    // illegal opcode: sticky fault, no retire, only reset leaves
    cyc(1'b0, 1'b1, 11'h000, 1'b0, 1'b1, o_fetch(1'b1), 32'd13, "ill_fetch");
    cyc(1'b0, 1'b1, 11'h000, 1'b0, 1'b1, o_base(S_D), 32'd13, "ill_decode");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 11'h000, 1'b0, 1'b1, o_fault(), 32'd13, "ill_sticky");
    cyc(1'b1, 1'b1, 11'h000, 1'b0, 1'b1, o_base(S_X), 32'd13, "ill_rst");
    cyc(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, o_base(S_F), 32'd0, "ill_cleared");

    // fetch never completes: fault after four stall cycles
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 11'h458, 1'b0, 1'b0, o_fetch(1'b0), 32'd0, "to_stall");
    cyc(1'b0, 1'b1, 11'h458, 1'b0, 1'b1, o_fault(), 32'd0, "to_fault");
    cyc(1'b0, 1'b1, 11'h458, 1'b0, 1'b1, o_fault(), 32'd0, "to_fault");
    cyc(1'b1, 1'b0, 11'h458, 1'b0, 1'b0, o_base(S_X), 32'd0, "to_rst");
    cyc(1'b0, 1'b0, 11'h458, 1'b0, 1'b0, o_base(S_F), 32'd0, "to_cleared");

    // reset during a stalled STUR write: no write strobe, fresh fetch next cycle
    cyc(1'b0, 1'b1, OP_STUR, 1'b0, 1'b1, o_fetch(1'b1), 32'd0, "rmid_fetch");
    cyc(1'b0, 1'b1, OP_STUR, 1'b0, 1'b1, o_base(S_D), 32'd0, "rmid_decode");
    cyc(1'b0, 1'b1, OP_STUR, 1'b0, 1'b1, o_exec(A_ADD, 1'b1), 32'd0, "rmid_exec");
    cyc(1'b0, 1'b1, OP_STUR, 1'b0, 1'b0, o_mem(1'b1), 32'd0, "rmid_mem");
    cyc(1'b1, 1'b1, OP_STUR, 1'b0, 1'b1, o_base(S_M), 32'd0, "rmid_rst");
    cyc(1'b0, 1'b1, OP_B, 1'b0, 1'b0, o_fetch(1'b0), 32'd0, "rmid_fresh");
    cyc(1'b0, 1'b0, OP_B, 1'b0, 1'b1, o_fetch(1'b1), 32'd0, "rmid_fetch_held");
    cyc(1'b0, 1'b0, OP_B, 1'b0, 1'b1, o_base(S_D), 32'd0, "rmid_b");
    cyc(1'b0, 1'b0, OP_B, 1'b0, 1'b1, o_branch(4'd0, 1'b1), 32'd0, "rmid_b");
    cyc(1'b0, 1'b0, OP_B, 1'b0, 1'b1, o_base(S_F), 32'd1, "rmid_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
